// File: rtl/rgb2yuv_pkg.sv
// Shared types and constants for the RGB to YUV (BT.601) converter.
package rgb2yuv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int PROD_W = 18;
  localparam int ACC_W  = 18;
  localparam int IDX_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  // Coefficients in idx order: Y(R,G,B), U(R,G,B), V(R,G,B)
  localparam logic signed [8:0] COEF [0:8] = '{
    9'sd77,   9'sd150,  9'sd29,
    -9'sd43,  -9'sd85,  9'sd128,
    9'sd128,  -9'sd107, -9'sd21
  };

  localparam int ADDR_RG   = 0;
  localparam int ADDR_B    = 1;
  localparam int ADDR_YU   = 0;
  localparam int ADDR_V    = 1;
  localparam int ADDR_STAT = 2;

  function automatic logic isChannelLast(input logic [IDX_W-1:0] idx);
    return (idx == 4'd2) || (idx == 4'd5) || (idx == 4'd8);
  endfunction

endpackage

// File: rtl/rgb2yuv_mac.sv
// Single-multiplier MAC with channel finalisation (shift, offset, optional round/saturate).
// Build option: define RGB2YUV_ROUND_EN for round-half-up plus 0..255 saturation.
module rgb2yuv_mac
  import rgb2yuv_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_last,
  input  logic              i_isUv,
  input  logic [7:0]        i_pixel,
  input  logic signed [8:0] i_coef,
  output logic [7:0]        o_result
);

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [8:0]        w_pixelExt;
  logic signed [PROD_W-1:0] w_product;
  logic signed [ACC_W-1:0]  w_sum;

  assign w_pixelExt = $signed({1'b0, i_pixel});
  assign w_product  = w_pixelExt * i_coef;
  assign w_sum      = r_acc + w_product;

  // Accumulator restarts at every channel boundary so each channel sums independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_last ? '0 : w_sum;
    end
  end

`ifdef RGB2YUV_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] UV_OFFSET  = ACC_W'(128);

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_offset;

  assign w_shifted = (w_sum + ROUND_BIAS) >>> FRAC_W;
  assign w_offset  = i_isUv ? (w_shifted + UV_OFFSET) : w_shifted;

  always_comb begin
    o_result = w_offset[7:0];
    if (w_offset < 0) begin
      o_result = 8'h00;
    end else if (w_offset > ACC_W'(255)) begin
      o_result = 8'hFF;
    end
  end
`else
  // Truncated result never leaves 0..255, so the low byte of the shifted sum is exact
  assign o_result = w_sum[FRAC_W+7:FRAC_W] + (i_isUv ? 8'd128 : 8'd0);
`endif

endmodule

// File: rtl/rgb2yuv_core.sv
// Host-register RGB to YUV converter: FSM, coefficient sequencing and register file.
// Build option: RGB2YUV_ROUND_EN (see rgb2yuv_mac) enables rounding and saturation.
module rgb2yuv_core
  import rgb2yuv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  output logic              Finish,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic              WrEn,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData
);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_R, r_G, r_B;
  logic [7:0]       r_opR, r_opG, r_opB;
  logic [7:0]       r_Y, r_U, r_V;
  logic             w_busy;
  logic             w_startAccept;
  logic             w_wrAccept;
  logic             w_last;
  logic [7:0]       w_pixel;
  logic [7:0]       w_macResult;

  assign w_startAccept = Start && (r_state != CALC);
  assign w_wrAccept    = WrEn && (r_state != CALC);
  assign w_last        = isChannelLast(r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (Start) w_nextState = CALC;
      CALC:    if (r_idx == LAST_IDX) w_nextState = DONE;
      DONE:    if (Start) w_nextState = CALC;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    Finish = (r_state == DONE);
    w_busy = (r_state == CALC);
  end

  // Operands are snapshotted on Start so a same-cycle write cannot affect the running pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_R   <= '0;  r_G   <= '0;  r_B   <= '0;
      r_opR <= '0;  r_opG <= '0;  r_opB <= '0;
      r_Y   <= '0;  r_U   <= '0;  r_V   <= '0;
    end else begin
      if (w_busy) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      else        r_idx <= '0;
      if (w_startAccept) begin
        r_opR <= r_R;
        r_opG <= r_G;
        r_opB <= r_B;
      end
      if (w_wrAccept && WrAddr == ADDR_W'(ADDR_RG)) begin
        r_R <= WrData[15:8];
        r_G <= WrData[7:0];
      end else if (w_wrAccept && WrAddr == ADDR_W'(ADDR_B)) begin
        r_B <= WrData[7:0];
      end
      if (w_busy && r_idx == 4'd2) r_Y <= w_macResult;
      if (w_busy && r_idx == 4'd5) r_U <= w_macResult;
      if (w_busy && r_idx == 4'd8) r_V <= w_macResult;
    end
  end

  always_comb begin
    case (r_idx)
      4'd0, 4'd3, 4'd6: w_pixel = r_opR;
      4'd1, 4'd4, 4'd7: w_pixel = r_opG;
      default:          w_pixel = r_opB;
    endcase
  end

  rgb2yuv_mac #(
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_busy),
    .i_last   (w_last),
    .i_isUv   (r_idx > 4'd2),
    .i_pixel  (w_pixel),
    .i_coef   (COEF[r_idx]),
    .o_result (w_macResult)
  );

  always_comb begin
    case (RdAddr)
      ADDR_W'(ADDR_YU):   RdData = DATA_W'({r_Y, r_U});
      ADDR_W'(ADDR_V):    RdData = DATA_W'(r_V);
      ADDR_W'(ADDR_STAT): RdData = DATA_W'(w_busy);
      default:            RdData = '0;
    endcase
  end

endmodule

// File: tb/tb_rgb2yuv_core.sv
// Self-checking bench for rgb2yuv_core: directed vectors, random pixels vs. a BT.601 model,
// and multi-cycle corner cases (mid-CALC writes/starts, same-cycle start+write, reset abort).
module tb_rgb2yuv_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        Finish;
  logic [1:0]  WrAddr;
  logic        WrEn;
  logic [15:0] WrData;
  logic [1:0]  RdAddr;
  logic [15:0] RdData;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rgb2yuv_core #(.DATA_W(16), .ADDR_W(2), .FRAC_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Finish (Finish),
    .WrAddr (WrAddr),
    .WrEn   (WrEn),
    .WrData (WrData),
    .RdAddr (RdAddr),
    .RdData (RdData)
  );

  typedef struct {
    string      name;
    logic [7:0] r, g, b;
    logic [15:0] expYU;
    logic [15:0] expV;
  } vec_t;

  // Reference: weighted sum per channel, floor-divide by 256, offset chroma by 128
  function automatic logic [7:0] chanModel(input int sum, input bit isUv);
    int v;
    v = sum;
`ifdef RGB2YUV_ROUND_EN
    v = v + 128;
`endif
    v = v >>> 8;
    if (isUv) v = v + 128;
`ifdef RGB2YUV_ROUND_EN
    if (v < 0) v = 0;
    if (v > 255) v = 255;
`endif
    return 8'(v);
  endfunction

  task automatic model(input int r, input int g, input int b,
                       output logic [15:0] yu, output logic [15:0] v);
    logic [7:0] y, u, vv;
    y  = chanModel(77 * r + 150 * g + 29 * b, 1'b0);
    u  = chanModel(-43 * r - 85 * g + 128 * b, 1'b1);
    vv = chanModel(128 * r - 107 * g - 21 * b, 1'b1);
    yu = {y, u};
    v  = {8'h00, vv};
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic readReg(input logic [1:0] a, output logic [15:0] d);
    RdAddr = a;
    #1;
    d = RdData;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    WrAddr = a; WrData = d; WrEn = 1'b1;
    @(negedge clk);
    WrEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    writeReg(2'd0, {r, g});
    writeReg(2'd1, {8'h00, b});
  endtask

  // Pulses Start (optionally with a simultaneous write) and returns edges until Finish, 0 on timeout
  task automatic runCalc(input bit withWr, input logic [1:0] a, input logic [15:0] d,
                         output int cycles);
    @(negedge clk);
    Start = 1'b1;
    if (withWr) begin WrAddr = a; WrData = d; WrEn = 1'b1; end
    @(posedge clk);
    #1;
    Start = 1'b0; WrEn = 1'b0;
    cycles = 0;
    checkOutput("finish_cleared_on_start", {15'b0, Finish}, 16'h0000);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (Finish) begin cycles = c; break; end
    end
    if (cycles == 0) $display("[TB] FAIL finish_timeout: got no Finish expected Finish within 20 cycles");
  endtask

  task automatic checkResult(input string name, input logic [15:0] expYU, input logic [15:0] expV);
    logic [15:0] d;
    readReg(2'd0, d);
    checkOutput({name, "_yu"}, d, expYU);
    readReg(2'd1, d);
    checkOutput({name, "_v"}, d, expV);
  endtask

  initial begin
    vec_t vecs[4];
    logic [15:0] d, eYU, eV, redYU, redV;
    int cyc;
    logic [7:0] r, g, b;

    vecs[0] = '{"white", 8'hFF, 8'hFF, 8'hFF, 16'hFF80, 16'h0080};
    vecs[1] = '{"black", 8'h00, 8'h00, 8'h00, 16'h0080, 16'h0080};
`ifdef RGB2YUV_ROUND_EN
    vecs[2] = '{"red",   8'hFF, 8'h00, 8'h00, 16'h4D55, 16'h00FF};
    vecs[3] = '{"blue",  8'h00, 8'h00, 8'hFF, 16'h1DFF, 16'h006B};
`else
    vecs[2] = '{"red",   8'hFF, 8'h00, 8'h00, 16'h4C55, 16'h00FF};
    vecs[3] = '{"blue",  8'h00, 8'h00, 8'hFF, 16'h1CFF, 16'h006B};
`endif

    rst_n = 1'b0; Start = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0; RdAddr = '0;
    #22;
    checkOutput("reset_finish", {15'b0, Finish}, 16'h0000);
    checkResult("reset", 16'h0000, 16'h0000);
    readReg(2'd2, d);
    checkOutput("reset_busy", d, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].g, vecs[i].b);
      runCalc(1'b0, 2'd0, 16'h0000, cyc);
      checkOutput({vecs[i].name, "_latency"}, 16'(cyc), 16'd9);
      checkResult(vecs[i].name, vecs[i].expYU, vecs[i].expV);
      readReg(2'd3, d);
      checkOutput({vecs[i].name, "_addr3"}, d, 16'h0000);
    end

    for (int n = 0; n < 16; n++) begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      model(int'(r), int'(g), int'(b), eYU, eV);
      applyStimulus(r, g, b);
      runCalc(1'b0, 2'd0, 16'h0000, cyc);
      checkOutput("rand_latency", 16'(cyc), 16'd9);
      checkResult($sformatf("rand%0d", n), eYU, eV);
    end

    // Mid-CALC write and Start must be ignored; busy visible only during CALC
    applyStimulus(8'h00, 8'h00, 8'hFF);
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin WrEn = 1'b0; Start = 1'b0; end
      if (Finish) begin cyc = c; break; end
      if (c == 4) begin
        WrAddr = 2'd0; WrData = 16'h1234; WrEn = 1'b1; Start = 1'b1;
        readReg(2'd2, d);
        checkOutput("busy_in_calc", d, 16'h0001);
      end
    end
    WrEn = 1'b0; Start = 1'b0;
    checkOutput("midcalc_latency", 16'(cyc), 16'd9);
    readReg(2'd2, d);
    checkOutput("busy_after_done", d, 16'h0000);
    checkResult("midcalc", vecs[3].expYU, vecs[3].expV);
    runCalc(1'b0, 2'd0, 16'h0000, cyc);
    checkResult("midcalc_write_ignored", vecs[3].expYU, vecs[3].expV);

    // Write in DONE keeps Finish and results
    writeReg(2'd0, 16'hFF00);
    checkOutput("done_write_finish", {15'b0, Finish}, 16'h0001);
    checkResult("done_write_keeps", vecs[3].expYU, vecs[3].expV);

    // Same-cycle Start+write: computation uses old operands (R=FF,G=0,B=FF -> B write to 0)
    model(255, 0, 255, eYU, eV);
    runCalc(1'b1, 2'd1, 16'h0000, cyc);
    checkOutput("samecycle_latency", 16'(cyc), 16'd9);
    checkResult("samecycle_old", eYU, eV);
    runCalc(1'b0, 2'd0, 16'h0000, cyc);
    checkResult("samecycle_new", vecs[2].expYU, vecs[2].expV);

    // Reset in the middle of CALC aborts everything
    applyStimulus(8'h80, 8'h40, 8'h20);
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_finish", {15'b0, Finish}, 16'h0000);
    checkResult("abort", 16'h0000, 16'h0000);
    readReg(2'd2, d);
    checkOutput("abort_busy", d, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    runCalc(1'b0, 2'd0, 16'h0000, cyc);
    checkOutput("post_reset_latency", 16'(cyc), 16'd9);
    checkResult("post_reset_black", 16'h0080, 16'h0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion expected completion before 200us");
    $fatal(1, "[TB] bench timed out");
  end

endmodule
